alu_ccr_controller: RTL and testbench

//  Execute-stage controller for the 16-bit ALU. Decodes the 5-bit opcode into the
//  ALU's one-hot select lines and owns the architectural CCR register {C,N,Z},

---
 rtl/alu_ccr_controller.sv | 138 +++++++++++++
 tb/tb_alu_ccr_controller.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ccr_controller.sv
// Execute-stage ALU controller: opcode decode, CCR {C,N,Z} ownership,
// flag-conditional jump resolution and a CCR shadow stack for interrupt/RTI.
module alu_ccr_controller #(
   parameter int SHADOW_DEPTH = 2,
   parameter int OPC_W        = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             valid,
   input  logic [OPC_W-1:0] opcode,
   input  logic             alu_z,
   input  logic             alu_n,
   input  logic             alu_c,
   input  logic             int_save,
   input  logic             rti_restore,
   output logic [11:0]      alu_sel,
   output logic [2:0]       ccr,
   output logic             jmp_taken,
   output logic [1:0]       shadow_cnt,
   output logic             err
);

   localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'('h00);
   localparam logic [OPC_W-1:0] OP_SETC = OPC_W'('h01);
   localparam logic [OPC_W-1:0] OP_CLRC = OPC_W'('h02);
   localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'('h03);
   localparam logic [OPC_W-1:0] OP_INC  = OPC_W'('h04);
   localparam logic [OPC_W-1:0] OP_DEC  = OPC_W'('h05);
   localparam logic [OPC_W-1:0] OP_OUT  = OPC_W'('h06);
   localparam logic [OPC_W-1:0] OP_IN   = OPC_W'('h07);
   localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'('h08);
   localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'('h09);
   localparam logic [OPC_W-1:0] OP_AND  = OPC_W'('h0A);
   localparam logic [OPC_W-1:0] OP_OR   = OPC_W'('h0B);
   localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'('h0C);
   localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'('h0D);
   localparam logic [OPC_W-1:0] OP_LDM  = OPC_W'('h0E);
   localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'('h10);
   localparam logic [OPC_W-1:0] OP_JN   = OPC_W'('h11);
   localparam logic [OPC_W-1:0] OP_JC   = OPC_W'('h12);

   localparam logic [1:0] DEPTH_C = 2'(SHADOW_DEPTH);

   logic       live;
   logic       upd_all, upd_zn, set_c, clr_c;
   logic       jz, jn, jc;
   logic [2:0] ccr_upd;
   logic [2:0] top;
   logic       full, empty;
   logic       push_ok, pop_ok, err_set;
   logic [2:0] stack [SHADOW_DEPTH];

   assign live = valid & en & ~flush;

   always_comb begin
      alu_sel = '0;
      upd_all = 1'b0;
      upd_zn  = 1'b0;
      set_c   = 1'b0;
      clr_c   = 1'b0;
      jz      = 1'b0;
      jn      = 1'b0;
      jc      = 1'b0;
      if (live) begin
         unique case (opcode)
            OP_ADD:  begin alu_sel[0]  = 1'b1; upd_all = 1'b1; end
            OP_NOT:  begin alu_sel[1]  = 1'b1; upd_zn  = 1'b1; end
            OP_INC:  begin alu_sel[2]  = 1'b1; upd_zn  = 1'b1; end
            OP_DEC:  begin alu_sel[3]  = 1'b1; upd_zn  = 1'b1; end
            OP_SUB:  begin alu_sel[4]  = 1'b1; upd_zn  = 1'b1; end
            OP_AND:  begin alu_sel[5]  = 1'b1; upd_zn  = 1'b1; end
            OP_OR:   begin alu_sel[6]  = 1'b1; upd_zn  = 1'b1; end
            OP_SHL:  begin alu_sel[7]  = 1'b1; upd_zn  = 1'b1; end
            OP_SHR:  begin alu_sel[8]  = 1'b1; upd_zn  = 1'b1; end
            OP_IN:   alu_sel[9]  = 1'b1;
            OP_OUT:  alu_sel[10] = 1'b1;
            OP_LDM:  alu_sel[11] = 1'b1;
            OP_SETC: set_c = 1'b1;
            OP_CLRC: clr_c = 1'b1;
            OP_JZ:   jz = 1'b1;
            OP_JN:   jn = 1'b1;
            OP_JC:   jc = 1'b1;
            OP_NOP:  ;
            default: ;
         endcase
      end
   end

   assign jmp_taken = (jz & ccr[0]) | (jn & ccr[1]) | (jc & ccr[2]);

   // A taken jump consumes the flag it tested.
   always_comb begin
      ccr_upd = ccr;
      if (upd_all) ccr_upd = {alu_c, alu_n, alu_z};
      if (upd_zn)  ccr_upd[1:0] = {alu_n, alu_z};
      if (set_c)   ccr_upd[2] = 1'b1;
      if (clr_c)   ccr_upd[2] = 1'b0;
      if (jz & ccr[0]) ccr_upd[0] = 1'b0;
      if (jn & ccr[1]) ccr_upd[1] = 1'b0;
      if (jc & ccr[2]) ccr_upd[2] = 1'b0;
   end

   always_comb begin
      top = '0;
      for (int i = 0; i < SHADOW_DEPTH; i++)
         if (shadow_cnt == 2'(i + 1)) top = stack[i];
   end

   assign full    = (shadow_cnt == DEPTH_C);
   assign empty   = (shadow_cnt == 2'd0);
   assign push_ok = int_save & ~rti_restore & ~full;
   assign pop_ok  = rti_restore & ~int_save & ~empty;
   assign err_set = (int_save & rti_restore)
                  | (int_save & ~rti_restore & full)
                  | (rti_restore & ~int_save & empty);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ccr        <= '0;
         shadow_cnt <= '0;
         err        <= 1'b0;
         for (int i = 0; i < SHADOW_DEPTH; i++) stack[i] <= '0;
      end else begin
         ccr <= pop_ok ? top : ccr_upd;
         err <= err | err_set;
         if (push_ok) begin
            shadow_cnt <= shadow_cnt + 2'd1;
            for (int i = 0; i < SHADOW_DEPTH; i++)
               if (shadow_cnt == 2'(i)) stack[i] <= ccr;
         end else if (pop_ok) begin
            shadow_cnt <= shadow_cnt - 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_alu_ccr_controller.sv
// Directed-vector bench for alu_ccr_controller.
module tb_alu_ccr_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, flush, valid;
   logic [4:0]  opcode;
   logic        alu_z, alu_n, alu_c;
   logic        int_save, rti_restore;
   logic [11:0] alu_sel;
   logic [2:0]  ccr;
   logic        jmp_taken;
   logic [1:0]  shadow_cnt;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   alu_ccr_controller #(.SHADOW_DEPTH(2), .OPC_W(5)) dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .valid(valid),
      .opcode(opcode), .alu_z(alu_z), .alu_n(alu_n), .alu_c(alu_c),
      .int_save(int_save), .rti_restore(rti_restore),
      .alu_sel(alu_sel), .ccr(ccr), .jmp_taken(jmp_taken),
      .shadow_cnt(shadow_cnt), .err(err)
   );

   task automatic drive(input logic v, input logic [4:0] op,
                        input logic z, input logic n, input logic c,
                        input logic s, input logic r);
      valid = v; opcode = op;
      alu_z = z; alu_n = n; alu_c = c;
      int_save = s; rti_restore = r;
      en = 1'b1; flush = 1'b0;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle();
      vectors++;
      if ({ccr, shadow_cnt, err, alu_sel} !== 18'h0) begin
         miscompares++;
         $display("FAIL reset_init: ccr=%b cnt=%0d err=%b sel=%h want 0",
                  ccr, shadow_cnt, err, alu_sel);
      end
      tick();
      rst = 1'b0;
      drive(1'b1, 5'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      vectors++;
      if (ccr !== 3'b111 || shadow_cnt !== 2'd1 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_pre: ccr=%b cnt=%0d err=%b want 111 1 1",
                  ccr, shadow_cnt, err);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({ccr, shadow_cnt, err, alu_sel} !== 18'h0) begin
         miscompares++;
         $display("FAIL reset_async: ccr=%b cnt=%0d err=%b sel=%h want 0",
                  ccr, shadow_cnt, err, alu_sel);
      end
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_decode();
      logic [4:0]  ops  [16];
      logic [11:0] sels [16];
      ops = '{5'h08, 5'h03, 5'h04, 5'h05, 5'h09, 5'h0A, 5'h0B, 5'h0C,
              5'h0D, 5'h07, 5'h06, 5'h0E, 5'h00, 5'h0F, 5'h13, 5'h1F};
      sels = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h010, 12'h020,
               12'h040, 12'h080, 12'h100, 12'h200, 12'h400, 12'h800,
               12'h000, 12'h000, 12'h000, 12'h000};
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, ops[i], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         vectors++;
         if (alu_sel !== sels[i] || jmp_taken !== 1'b0) begin
            miscompares++;
            $display("FAIL decode op=%h: sel=%h jmp=%b want %h 0",
                     ops[i], alu_sel, jmp_taken, sels[i]);
         end
      end
      idle();
   endtask

   task automatic test_add_sub();
      drive(1'b1, 5'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (alu_sel !== 12'h001) begin
         miscompares++;
         $display("FAIL add_sel: got %h want 001", alu_sel);
      end
      tick();
      vectors++;
      if (ccr !== 3'b100) begin
         miscompares++;
         $display("FAIL add_ccr: got %b want 100", ccr);
      end
      drive(1'b1, 5'h09, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (alu_sel !== 12'h010) begin
         miscompares++;
         $display("FAIL sub_sel: got %h want 010", alu_sel);
      end
      tick();
      vectors++;
      if (ccr !== 3'b101) begin
         miscompares++;
         $display("FAIL sub_ccr: got %b want 101", ccr);
      end
      drive(1'b1, 5'h0E, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b101) begin
         miscompares++;
         $display("FAIL ldm_hold: got %b want 101", ccr);
      end
   endtask

   task automatic test_jump();
      drive(1'b1, 5'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b001) begin
         miscompares++;
         $display("FAIL clrc: got %b want 001", ccr);
      end
      drive(1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b101) begin
         miscompares++;
         $display("FAIL setc: got %b want 101", ccr);
      end
      drive(1'b1, 5'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jmp_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL jc_taken: got %b want 1", jmp_taken);
      end
      tick();
      vectors++;
      if (ccr !== 3'b001) begin
         miscompares++;
         $display("FAIL jc_clear: got %b want 001", ccr);
      end
      vectors++;
      if (jmp_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL jc_again: got %b want 0", jmp_taken);
      end
      drive(1'b1, 5'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jmp_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL jn_nottaken: got %b want 0", jmp_taken);
      end
      drive(1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (jmp_taken !== 1'b1) begin
         miscompares++;
         $display("FAIL jz_taken: got %b want 1", jmp_taken);
      end
      tick();
      vectors++;
      if (ccr !== 3'b000) begin
         miscompares++;
         $display("FAIL jz_clear: got %b want 000", ccr);
      end
      idle();
   endtask

   task automatic test_shadow();
      drive(1'b1, 5'h08, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b011 || shadow_cnt !== 2'd1) begin
         miscompares++;
         $display("FAIL save: ccr=%b cnt=%0d want 011 1", ccr, shadow_cnt);
      end
      drive(1'b1, 5'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b100) begin
         miscompares++;
         $display("FAIL add_between: got %b want 100", ccr);
      end
      drive(1'b1, 5'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      tick();
      vectors++;
      if (ccr !== 3'b011 || shadow_cnt !== 2'd0 || err !== 1'b0) begin
         miscompares++;
         $display("FAIL restore: ccr=%b cnt=%0d err=%b want 011 0 0",
                  ccr, shadow_cnt, err);
      end
      idle();
   endtask

   task automatic test_overflow();
      drive(1'b1, 5'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b111 || shadow_cnt !== 2'd1) begin
         miscompares++;
         $display("FAIL push1: ccr=%b cnt=%0d want 111 1", ccr, shadow_cnt);
      end
      drive(1'b1, 5'h08, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 5'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      vectors++;
      if (ccr !== 3'b010 || shadow_cnt !== 2'd2 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL push3: ccr=%b cnt=%0d err=%b want 010 2 1",
                  ccr, shadow_cnt, err);
      end
      drive(1'b0, 5'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      vectors++;
      if (ccr !== 3'b111 || shadow_cnt !== 2'd1) begin
         miscompares++;
         $display("FAIL pop1: ccr=%b cnt=%0d want 111 1", ccr, shadow_cnt);
      end
      tick();
      vectors++;
      if (ccr !== 3'b011 || shadow_cnt !== 2'd0) begin
         miscompares++;
         $display("FAIL pop2: ccr=%b cnt=%0d want 011 0", ccr, shadow_cnt);
      end
      tick();
      vectors++;
      if (ccr !== 3'b011 || shadow_cnt !== 2'd0 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL pop3: ccr=%b cnt=%0d err=%b want 011 0 1",
                  ccr, shadow_cnt, err);
      end
      idle();
   endtask

   task automatic test_stall();
      do_reset();
      drive(1'b1, 5'h08, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      en = 1'b0;
      #1;
      vectors++;
      if (alu_sel !== 12'h000) begin
         miscompares++;
         $display("FAIL stall_sel: got %h want 000", alu_sel);
      end
      tick();
      vectors++;
      if (ccr !== 3'b000) begin
         miscompares++;
         $display("FAIL stall_ccr: got %b want 000", ccr);
      end
      en = 1'b1;
      flush = 1'b1;
      #1;
      vectors++;
      if (alu_sel !== 12'h000) begin
         miscompares++;
         $display("FAIL flush_sel: got %h want 000", alu_sel);
      end
      tick();
      vectors++;
      if (ccr !== 3'b000) begin
         miscompares++;
         $display("FAIL flush_ccr: got %b want 000", ccr);
      end
      flush = 1'b0;
      tick();
      drive(1'b1, 5'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      en = 1'b0;
      #1;
      vectors++;
      if (jmp_taken !== 1'b0) begin
         miscompares++;
         $display("FAIL stall_jmp: got %b want 0", jmp_taken);
      end
      tick();
      vectors++;
      if (ccr !== 3'b111) begin
         miscompares++;
         $display("FAIL stall_jz_ccr: got %b want 111", ccr);
      end
      drive(1'b1, 5'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      vectors++;
      if (ccr !== 3'b000 || shadow_cnt !== 2'd0 || err !== 1'b1) begin
         miscompares++;
         $display("FAIL collide: ccr=%b cnt=%0d err=%b want 000 0 1",
                  ccr, shadow_cnt, err);
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_decode();
      test_add_sub();
      test_jump();
      test_shadow();
      test_overflow();
      test_stall();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
